vid_sram_drain: RTL and testbench
=================================

VID_SRAM_DRAIN -- requirements
Module: vid_sram_drain

Interface
REQ-001 Parameter Q, default 16, vertex IDs per SRAM row.
REQ-002 Parameter VID_BW, default 16, bits per vertex ID.
REQ-003 Parameter K, default 16, number of vid SRAM banks.
REQ-004 Parameter ADDR_SPACE, default 4, SRAM address width (16 rows per bank).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle pulse: begin draining all banks.
REQ-008 fill_cnt  input  K*(ADDR_SPACE+1)  valid rows per bank, bank b at bits [b*(ADDR_SPACE+1) +: ADDR_SPACE+1].
REQ-009 vid_sram_raddr  output  ADDR_SPACE  read address shared by all banks.
REQ-010 vid_sram_rdata  input  K*Q*VID_BW  concatenated read data, bank b at [b*Q*VID_BW +: Q*VID_BW], valid one cycle after raddr.
REQ-011 out_valid  output  1  out_* beat valid.
REQ-012 out_ready  input  1  consumer accepts beat when out_valid and out_ready both high at a rising edge.
REQ-013 out_bank  output  log2(K)  bank of current beat.
REQ-014 out_addr  output  ADDR_SPACE  row of current beat.
REQ-015 out_data  output  Q*VID_BW  row contents.
REQ-016 busy  output  1  high from start acceptance until done.
REQ-017 done  output  1  one-cycle pulse after final beat accepted.
REQ-018 checksum  output  VID_BW  running XOR of streamed vertex IDs (see Configuration).

Function
REQ-019 FSM states IDLE, ISSUE, FLUSH; start in IDLE -> ISSUE, captures fill_cnt, clamps each value >2^ADDR_SPACE to 2^ADDR_SPACE; start outside IDLE ignored.
REQ-020 Traversal order: bank 0..K-1 ascending, within bank row 0..fill_cnt[b]-1 ascending; banks with fill 0 emit no beat and cost at most one cycle each.
REQ-021 Read latency: raddr issued in cycle n, rdata registered at edge n+1 into a 2-entry output FIFO; first out_valid no earlier than 2 cycles after the start edge.
REQ-022 Read issue only when FIFO occupancy plus in-flight reads < 2; no row dropped or duplicated under any out_ready pattern.
REQ-023 With out_ready held high, sustained throughput 1 beat per cycle.
REQ-024 out_bank/out_addr/out_data held stable while out_valid high and out_ready low.
REQ-025 ISSUE -> FLUSH after last row issued; FLUSH -> IDLE when FIFO empty and no read in flight, pulsing done for one cycle and dropping busy the same cycle.
REQ-026 All fill_cnt zero: no beats, done pulses 2 cycles after start, busy high for those cycles.
REQ-027 vid_sram_raddr holds last issued value when not issuing.

Reset
REQ-028 rst_n low asynchronously forces IDLE, FIFO empty, in-flight cleared, out_valid=0, busy=0, done=0, vid_sram_raddr=0, out_bank=0, out_addr=0, out_data=0, checksum=0.
REQ-029 Reset mid-drain abandons traversal; first start after release begins at bank 0 row 0.

Configuration
REQ-030 Macro VID_DRAIN_CHECKSUM_EN defined: checksum cleared at start acceptance, XOR-accumulates all Q IDs of each accepted beat, holds after done.
REQ-031 Macro undefined: checksum tied to 0, no accumulator logic; all other behaviour identical.

Verification
REQ-032 fill_cnt all 1, out_ready=1, start -> 16 beats banks 0..15 addr 0 on consecutive cycles, done once after beat 15.
REQ-033 fill bank3=16 others 0, out_ready toggling 1,0 -> 16 beats bank 3 addr 0..15, data stable across stalls, no loss.
REQ-034 fill all 0, start -> no out_valid, done 2 cycles after start.
REQ-035 fill bank0=20 -> clamped, exactly 16 beats addr 0..15.
REQ-036 rst_n low after 5 beats, release, start -> stream restarts bank 0 row 0, busy=0 during reset.
REQ-037 VID_DRAIN_CHECKSUM_EN, bank0 row0 IDs 0x0001..0x0010, fill bank0=1 -> checksum 0x0010; without macro -> 0x0000.

Source files
------------

// File: rtl/vid_sram_drain.sv
// Streams every valid row of K vertex-ID SRAM banks out over a valid/ready port.
// Optional running XOR checksum of the streamed IDs is built only with VID_DRAIN_CHECKSUM_EN.
module vid_sram_drain #(
  parameter int Q          = 16,
  parameter int VID_BW     = 16,
  parameter int K          = 16,
  parameter int ADDR_SPACE = 4,
  localparam int BANK_W    = (K > 1) ? $clog2(K) : 1,
  localparam int FILL_W    = ADDR_SPACE + 1,
  localparam int ROW_W     = Q * VID_BW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [K*FILL_W-1:0]     fill_cnt,
  output logic [ADDR_SPACE-1:0]   vid_sram_raddr,
  input  logic [K*ROW_W-1:0]      vid_sram_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BANK_W-1:0]       out_bank,
  output logic [ADDR_SPACE-1:0]   out_addr,
  output logic [ROW_W-1:0]        out_data,
  output logic                    busy,
  output logic                    done,
  output logic [VID_BW-1:0]       checksum,
  output logic [1:0]              dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [FILL_W-1:0] FILL_MAX = {1'b1, {ADDR_SPACE{1'b0}}};

  // Output handshake: a beat transfers on a rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low the
  // beat (out_bank/out_addr/out_data) is held unchanged.

  logic [1:0]            state_q, state_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [FILL_W-1:0]     row_q, row_d;
  logic                  done_q, done_d;
  logic [FILL_W-1:0]     fill_q [K];
  logic [FILL_W-1:0]     fill_in [K];
  logic [ADDR_SPACE-1:0] raddr_q;

  logic                  inflight_q;
  logic [BANK_W-1:0]     inf_bank_q;
  logic [ADDR_SPACE-1:0] inf_addr_q;

  logic [ROW_W-1:0]      fifo_data_q [2];
  logic [BANK_W-1:0]     fifo_bank_q [2];
  logic [ADDR_SPACE-1:0] fifo_addr_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q;

  logic                  start_found, nxt_found;
  logic [BANK_W-1:0]     start_bank, nxt_bank;
  logic [FILL_W-1:0]     fill_cur;
  logic                  pop, push, can_issue, last_row, accept_start;
  logic [2:0]            occ;

  always_comb begin
    for (int b = 0; b < K; b++) begin
      fill_in[b] = (fill_cnt[b*FILL_W +: FILL_W] > FILL_MAX) ? FILL_MAX
                                                             : fill_cnt[b*FILL_W +: FILL_W];
    end
  end

  // Empty banks are skipped by jumping straight to the next non-empty one.
  always_comb begin
    start_found = 1'b0;
    start_bank  = '0;
    nxt_found   = 1'b0;
    nxt_bank    = '0;
    for (int b = K - 1; b >= 0; b--) begin
      if (fill_in[b] != '0) begin
        start_found = 1'b1;
        start_bank  = BANK_W'(b);
      end
      if ((b > int'(bank_q)) && (fill_q[b] != '0)) begin
        nxt_found = 1'b1;
        nxt_bank  = BANK_W'(b);
      end
    end
  end

  assign accept_start = (state_q == IDLE) && start;
  assign fill_cur     = fill_q[bank_q];
  assign last_row     = ((row_q + FILL_W'(1)) == fill_cur);
  assign pop          = out_valid && out_ready;
  assign push         = inflight_q;
  // A slot freed by this cycle's pop counts, so a full pipeline still issues every cycle.
  assign occ          = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
  assign can_issue    = (state_q == ISSUE) && (occ < 3'd2);

  assign vid_sram_raddr = can_issue ? row_q[ADDR_SPACE-1:0] : raddr_q;

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_d = '0;
          if (start_found) begin
            state_d = ISSUE;
            bank_d  = start_bank;
          end else begin
            state_d = FLUSH;
            bank_d  = '0;
          end
        end
      end
      ISSUE: begin
        if (can_issue) begin
          if (last_row) begin
            row_d = '0;
            if (nxt_found) bank_d = nxt_bank;
            else           state_d = FLUSH;
          end else begin
            row_d = row_q + FILL_W'(1);
          end
        end
      end
      FLUSH: begin
        if ((cnt_q == 2'd0) && !inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bank_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      raddr_q <= '0;
      for (int b = 0; b < K; b++) fill_q[b] <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      done_q  <= done_d;
      if (can_issue) raddr_q <= row_q[ADDR_SPACE-1:0];
      if (accept_start) begin
        for (int b = 0; b < K; b++) fill_q[b] <= fill_in[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      inf_bank_q <= '0;
      inf_addr_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_bank_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
    end else begin
      inflight_q <= can_issue;
      if (can_issue) begin
        inf_bank_q <= bank_q;
        inf_addr_q <= row_q[ADDR_SPACE-1:0];
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= vid_sram_rdata[int'(inf_bank_q)*ROW_W +: ROW_W];
        fifo_bank_q[wr_ptr_q] <= inf_bank_q;
        fifo_addr_q[wr_ptr_q] <= inf_addr_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_bank  = fifo_bank_q[rd_ptr_q];
  assign out_addr  = fifo_addr_q[rd_ptr_q];
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

`ifdef VID_DRAIN_CHECKSUM_EN
  logic [VID_BW-1:0] chk_q;
  logic [VID_BW-1:0] beat_xor;

  always_comb begin
    beat_xor = '0;
    for (int i = 0; i < Q; i++) beat_xor = beat_xor ^ out_data[i*VID_BW +: VID_BW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            chk_q <= '0;
    else if (accept_start) chk_q <= '0;
    else if (pop)          chk_q <= chk_q ^ beat_xor;
  end

  assign checksum = chk_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_vid_sram_drain.sv
// Directed bench for vid_sram_drain: registered SRAM model, expected-beat queue,
// stall-stability checks and a single summary line.
module tb_vid_sram_drain;
  localparam int K  = 16;
  localparam int Q  = 16;
  localparam int VW = 16;
  localparam int AS = 4;
  localparam int RW = Q * VW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [K*5-1:0]    fill_cnt;
  logic [AS-1:0]     raddr;
  logic [K*RW-1:0]   rdata;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_bank;
  logic [AS-1:0]     out_addr;
  logic [RW-1:0]     out_data;
  logic              busy;
  logic              done;
  logic [VW-1:0]     checksum;
  logic [1:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  exp_q[$];
  logic [4:0]  fill_arr [K];
  logic [15:0] chk_exp;

  int n_beats, n_done, gaps, first_beat, last_beat, done_cyc, busy_c1, end_cyc;

  vid_sram_drain dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fill_cnt(fill_cnt),
    .vid_sram_raddr(raddr), .vid_sram_rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_bank(out_bank),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done),
    .checksum(checksum), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] gen_row(input int b, input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int i = 0; i < Q; i++) begin
      if (b == 0 && r == 0) v[i*VW +: VW] = 16'(i + 1);
      else                  v[i*VW +: VW] = {b[3:0], r[3:0], 4'h5, i[3:0]};
    end
    return v;
  endfunction

  function automatic logic [15:0] row_xor(input logic [RW-1:0] v);
    logic [15:0] x;
    x = '0;
    for (int i = 0; i < Q; i++) x = x ^ v[i*VW +: VW];
    return x;
  endfunction

  // Registered-read SRAM: data for the address seen at an edge appears after it.
  always @(posedge clk) begin
    for (int b = 0; b < K; b++) rdata[b*RW +: RW] <= gen_row(b, int'(raddr));
  end

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_fill();
    for (int b = 0; b < K; b++) fill_cnt[b*5 +: 5] = fill_arr[b];
  endtask

  task automatic fill_all(input logic [4:0] v);
    for (int b = 0; b < K; b++) fill_arr[b] = v;
    set_fill();
  endtask

  task automatic build_exp();
    int n;
    exp_q.delete();
    for (int b = 0; b < K; b++) begin
      n = (fill_arr[b] > 5'd16) ? 16 : int'(fill_arr[b]);
      for (int r = 0; r < n; r++) exp_q.push_back({b[3:0], r[3:0]});
    end
  endtask

  // mode 0: ready high; 1: ready toggles 1,0,...; 2: random ready.
  task automatic run_drain(input int mode, input int stop_after, input int max_cyc);
    int cyc, post;
    logic held;
    logic [3:0] h_bank;
    logic [AS-1:0] h_addr;
    logic [RW-1:0] h_data;
    logic [7:0] e;
    n_beats = 0; n_done = 0; gaps = 0; first_beat = -1; last_beat = -1;
    done_cyc = -1; busy_c1 = 0; chk_exp = '0; held = 1'b0; cyc = 0; post = 0;
    h_bank = '0; h_addr = '0; h_data = '0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    while (cyc < max_cyc && post < 3) begin
      @(negedge clk);
      if (cyc == 1) busy_c1 = int'(busy);
      if (held) begin
        check("hold_bank", out_bank, h_bank);
        check("hold_addr", out_addr, h_addr);
        check("hold_data", out_data, h_data);
      end
      if (out_valid && out_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_bank", out_bank, e[7:4]);
          check("beat_addr", out_addr, e[3:0]);
          check("beat_data", out_data, gen_row(int'(e[7:4]), int'(e[3:0])));
          chk_exp = chk_exp ^ row_xor(gen_row(int'(e[7:4]), int'(e[3:0])));
        end
        if (last_beat >= 0 && last_beat != cyc - 1) gaps++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        n_beats++;
      end
      held = out_valid && !out_ready;
      h_bank = out_bank; h_addr = out_addr; h_data = out_data;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
      end
      if (n_done > 0) post++;
      if (stop_after > 0 && n_beats >= stop_after) break;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      case (mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
    end_cyc = cyc;
    start = 1'b0;
    check("no_timeout", end_cyc < max_cyc, 1);
  endtask

  task automatic check_end(input string tag, input int beats);
    check({tag, "_beats"}, n_beats, beats);
    check({tag, "_done_once"}, n_done, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_idle"}, busy, 0);
`ifdef VID_DRAIN_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, chk_exp);
`else
    check({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_raddr"}, raddr, 0);
    check({tag, "_bank"}, out_bank, 0);
    check({tag, "_addr"}, out_addr, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_checksum"}, checksum, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; fill_cnt = '0;
    for (int b = 0; b < K; b++) fill_arr[b] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All banks one row: back-to-back beats, one per cycle.
    fill_all(5'd1);
    build_exp();
    run_drain(0, 0, 200);
    check_end("all1", 16);
    check("all1_no_gaps", gaps, 0);
    check("all1_first_latency_ge2", first_beat >= 2, 1);
    check("all1_done_after_last", done_cyc > last_beat, 1);

    // Single full bank with ready toggling.
    fill_all(5'd0);
    fill_arr[3] = 5'd16;
    set_fill();
    build_exp();
    run_drain(1, 0, 400);
    check_end("bank3_stall", 16);

    // Nothing to drain.
    fill_all(5'd0);
    build_exp();
    run_drain(0, 0, 50);
    check("empty_beats", n_beats, 0);
    check("empty_done_cycle", done_cyc, 2);
    check("empty_busy_c1", busy_c1, 1);
    check("empty_done_once", n_done, 1);

    // Oversized fill is clamped to 16 rows.
    fill_all(5'd0);
    fill_arr[0] = 5'd20;
    set_fill();
    build_exp();
    run_drain(0, 0, 200);
    check_end("clamp", 16);

    // Mixed fills, random backpressure.
    fill_all(5'd0);
    fill_arr[0] = 5'd2; fill_arr[2] = 5'd16; fill_arr[5] = 5'd3;
    fill_arr[9] = 5'd31; fill_arr[15] = 5'd1;
    set_fill();
    build_exp();
    run_drain(2, 0, 2000);
    check_end("mixed_rand", 38);

    // Reset in the middle of a drain, then restart from bank 0 row 0.
    fill_all(5'd1);
    build_exp();
    run_drain(0, 5, 200);
    check("mid_beats", n_beats, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(posedge clk);
    #1;
    check("midreset_busy_held", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    build_exp();
    run_drain(0, 0, 200);
    check_end("restart", 16);
    check("restart_no_gaps", gaps, 0);

    // Checksum of the single row with IDs 1..16.
    fill_all(5'd0);
    fill_arr[0] = 5'd1;
    set_fill();
    build_exp();
    run_drain(0, 0, 100);
    check("cksum_beats", n_beats, 1);
`ifdef VID_DRAIN_CHECKSUM_EN
    check("cksum_value", checksum, 16'h0010);
`else
    check("cksum_value", checksum, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
